// File: rtl/rf_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_arbiter_pkg
// Purpose : Shared register-file constants for the regfile and its writeback
//           arbiter (default address/data widths and the hardwired-zero
//           register index).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rf_writeback_arbiter_pkg;

    localparam int RF_SCALE = 3;    // register address width
    localparam int RF_WIDTH = 32;   // register data width
    localparam int REG_ZERO = 0;    // index of the hardwired-zero register

endpackage : rf_writeback_arbiter_pkg
`default_nettype wire

// File: rtl/rf_writeback_arbiter_wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo2
// Purpose : Two-entry FIFO holding {wa, wd} results from the long-latency
//           port until the register-file write port is free.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           push, push_data - enqueue request and payload (ignored when full)
//           pop,  pop_data  - dequeue request and head payload (ignored when empty)
//           full, empty     - occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo2 #(
    parameter int DW = 35
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic          w_push;
    logic          w_pop;

    assign full     = (r_count == 2'd2);
    assign empty    = (r_count == 2'd0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_fifo2
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_arbiter
// Purpose : Single write-port master of the register file. Merges in-order
//           pipeline writeback (port A, highest priority) with buffered
//           long-latency results (port B), and keeps a per-register busy
//           scoreboard for the hazard unit.
// Ports   : clk, rst                    - clock, async active-high reset
//           a_we, a_wa, a_wd            - pipeline writeback
//           b_valid, b_ready, b_wa, b_wd- long-latency result handshake
//           iss_valid, iss_rd           - long-latency issue (sets busy)
//           rf_we, rf_wa, rf_wd         - register-file write port
//           busy                        - outstanding port-B destinations
//           stall_req                   - B queue full, pipeline must bubble
// Revision: 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int SCALE = RF_SCALE,
    parameter int WIDTH = RF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_we,
    input  logic [SCALE-1:0]    a_wa,
    input  logic [WIDTH-1:0]    a_wd,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [SCALE-1:0]    b_wa,
    input  logic [WIDTH-1:0]    b_wd,
    input  logic                iss_valid,
    input  logic [SCALE-1:0]    iss_rd,
    output logic                rf_we,
    output logic [SCALE-1:0]    rf_wa,
    output logic [WIDTH-1:0]    rf_wd,
    output logic [2**SCALE-1:0] busy,
    output logic                stall_req
);

    localparam logic [SCALE-1:0] c_zero_wa = SCALE'(REG_ZERO);
    localparam int               c_nregs   = 2**SCALE;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [SCALE+WIDTH-1:0] w_head;
    logic [SCALE-1:0]       w_head_wa;
    logic [WIDTH-1:0]       w_head_wd;
    logic                   w_a_sel;
    logic                   w_b_wr;
    logic [c_nregs-1:0]     r_busy;
    logic [c_nregs-1:0]     w_busy_nxt;

    // b_ready deliberately ignores a same-cycle pop so it never depends on a_we.
    assign b_ready   = !w_full;
    assign stall_req = w_full;
    assign w_push    = b_valid && !w_full;

    wb_fifo2 #(
        .DW (SCALE + WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({b_wa, b_wd}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head_wa = w_head[SCALE+WIDTH-1:WIDTH];
    assign w_head_wd = w_head[WIDTH-1:0];

    // A write to reg 0 is a no-op, so it leaves the port free for the FIFO.
    assign w_a_sel = a_we && (a_wa != c_zero_wa);
    assign w_pop   = !w_a_sel && !w_empty;
    // Entries targeting reg 0 are still popped, but never reach the regfile.
    assign w_b_wr  = w_pop && (w_head_wa != c_zero_wa);

    // Idle cycles must present wa=0/wd=0: the regfile forwards wd whenever
    // ra==wa regardless of we, so a stale address would corrupt reads.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (w_a_sel) begin
            rf_we = 1'b1;
            rf_wa = a_wa;
            rf_wd = a_wd;
        end else if (w_b_wr) begin
            rf_we = 1'b1;
            rf_wa = w_head_wa;
            rf_wd = w_head_wd;
        end
    end

    // Clear is applied before set so a same-cycle issue to the register being
    // retired keeps it busy for the newer operation.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_wa] = 1'b0;
        end
        if (iss_valid && (iss_rd != c_zero_wa)) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule : rf_writeback_arbiter
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_writeback_arbiter
// Purpose : Directed self-checking bench for rf_writeback_arbiter. Inputs
//           change on the falling edge; outputs are checked 1 ns later.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_writeback_arbiter;

    localparam int SCALE = 3;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             a_we;
    logic [SCALE-1:0] a_wa;
    logic [WIDTH-1:0] a_wd;
    logic             b_valid;
    logic             b_ready;
    logic [SCALE-1:0] b_wa;
    logic [WIDTH-1:0] b_wd;
    logic             iss_valid;
    logic [SCALE-1:0] iss_rd;
    logic             rf_we;
    logic [SCALE-1:0] rf_wa;
    logic [WIDTH-1:0] rf_wd;
    logic [7:0]       busy;
    logic             stall_req;

    int total = 0;
    int bad   = 0;

    rf_writeback_arbiter #(
        .SCALE (SCALE),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_we      (a_we),
        .a_wa      (a_wa),
        .a_wd      (a_wd),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_wa      (b_wa),
        .b_wd      (b_wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wport(input string tag, input logic we, input logic [SCALE-1:0] wa,
                         input logic [WIDTH-1:0] wd);
        chk({tag, ".we"}, 64'(rf_we), 64'(we));
        chk({tag, ".wa"}, 64'(rf_wa), 64'(wa));
        chk({tag, ".wd"}, 64'(rf_wd), 64'(wd));
    endtask

    task automatic idle();
        a_we = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    // advance to the next falling edge, inputs already cleared
    task automatic next_cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk); #1;
        wport("reset", 1'b0, 3'd0, 32'h0);
        chk("reset.busy", 64'(busy), 64'h00);
        chk("reset.b_ready", 64'(b_ready), 64'h1);
        chk("reset.stall", 64'(stall_req), 64'h0);
        rst = 1'b0;

        // A only: same-cycle write
        next_cyc(); a_we = 1'b1; a_wa = 3'd3; a_wd = 32'h1234; #1;
        wport("a_only", 1'b1, 3'd3, 32'h1234);
        chk("a_only.busy", 64'(busy), 64'h00);

        // A to reg 0 is suppressed and blanked
        next_cyc(); a_we = 1'b1; a_wa = 3'd0; a_wd = 32'hFFFF; #1;
        wport("a_reg0", 1'b0, 3'd0, 32'h0);

        // B through FIFO with scoreboard
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd5;
        next_cyc(); b_valid = 1'b1; b_wa = 3'd5; b_wd = 32'hABCD; #1;
        chk("b.busy_set", 64'(busy), 64'h20);
        chk("b.ready", 64'(b_ready), 64'h1);
        wport("b.before_push", 1'b0, 3'd0, 32'h0);
        next_cyc(); #1;
        wport("b.write", 1'b1, 3'd5, 32'hABCD);
        chk("b.busy_hold", 64'(busy), 64'h20);
        next_cyc(); #1;
        chk("b.busy_clr", 64'(busy), 64'h00);
        wport("b.after", 1'b0, 3'd0, 32'h0);

        // Contention: A every cycle while B pushes regs 2 then 4
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd2;
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd4;
        next_cyc(); a_we = 1'b1; a_wa = 3'd1; a_wd = 32'h11;
        b_valid = 1'b1; b_wa = 3'd2; b_wd = 32'h22; #1;
        wport("cont.c0", 1'b1, 3'd1, 32'h11);
        chk("cont.c0.ready", 64'(b_ready), 64'h1);
        next_cyc(); a_we = 1'b1; a_wa = 3'd1; a_wd = 32'h12;
        b_valid = 1'b1; b_wa = 3'd4; b_wd = 32'h44; #1;
        wport("cont.c1", 1'b1, 3'd1, 32'h12);
        chk("cont.c1.stall", 64'(stall_req), 64'h0);
        next_cyc(); a_we = 1'b1; a_wa = 3'd3; a_wd = 32'h33; #1;
        chk("cont.full.stall", 64'(stall_req), 64'h1);
        chk("cont.full.ready", 64'(b_ready), 64'h0);
        chk("cont.full.busy", 64'(busy), 64'h14);
        wport("cont.full", 1'b1, 3'd3, 32'h33);
        next_cyc(); #1;   // bubble: reg 2 drains
        wport("cont.drain2", 1'b1, 3'd2, 32'h22);
        next_cyc(); a_we = 1'b1; a_wa = 3'd1; a_wd = 32'h13; #1;
        chk("cont.unstall", 64'(stall_req), 64'h0);
        chk("cont.ready_back", 64'(b_ready), 64'h1);
        chk("cont.busy2_clr", 64'(busy), 64'h10);
        wport("cont.a_again", 1'b1, 3'd1, 32'h13);
        next_cyc(); #1;   // next A-idle cycle: reg 4 drains
        wport("cont.drain4", 1'b1, 3'd4, 32'h44);
        next_cyc(); #1;
        chk("cont.busy_empty", 64'(busy), 64'h00);
        wport("cont.idle", 1'b0, 3'd0, 32'h0);

        // A to reg 0 still lets the FIFO drain
        next_cyc(); b_valid = 1'b1; b_wa = 3'd7; b_wd = 32'h77;
        next_cyc(); a_we = 1'b1; a_wa = 3'd0; a_wd = 32'h5555; #1;
        wport("a0_drain", 1'b1, 3'd7, 32'h77);

        // Set/clear collision on reg 6
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd6;
        next_cyc(); b_valid = 1'b1; b_wa = 3'd6; b_wd = 32'h66;
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd6; #1;
        wport("coll.write", 1'b1, 3'd6, 32'h66);
        next_cyc(); #1;
        chk("coll.busy_kept", 64'(busy), 64'h40);
        wport("coll.after", 1'b0, 3'd0, 32'h0);

        // FIFO entry targeting reg 0 is popped silently
        next_cyc(); b_valid = 1'b1; b_wa = 3'd0; b_wd = 32'hDEAD;
        next_cyc(); #1;
        wport("b_reg0", 1'b0, 3'd0, 32'h0);
        chk("b_reg0.ready", 64'(b_ready), 64'h1);
        next_cyc(); #1;
        chk("b_reg0.drained", 64'(stall_req), 64'h0);

        // Reset mid-cycle with two entries queued
        next_cyc(); iss_valid = 1'b1; iss_rd = 3'd3;
        next_cyc(); a_we = 1'b1; a_wa = 3'd1; a_wd = 32'h1;
        b_valid = 1'b1; b_wa = 3'd3; b_wd = 32'h333;
        next_cyc(); a_we = 1'b1; a_wa = 3'd1; a_wd = 32'h2;
        b_valid = 1'b1; b_wa = 3'd5; b_wd = 32'h555;
        next_cyc(); #1;
        chk("rst.pre_stall", 64'(stall_req), 64'h1);
        wport("rst.pre_head", 1'b1, 3'd3, 32'h333);
        #2; rst = 1'b1; #1;
        wport("rst.mid", 1'b0, 3'd0, 32'h0);
        chk("rst.mid.busy", 64'(busy), 64'h00);
        chk("rst.mid.ready", 64'(b_ready), 64'h1);
        chk("rst.mid.stall", 64'(stall_req), 64'h0);
        next_cyc(); rst = 1'b0;
        next_cyc(); #1;
        wport("rst.after", 1'b0, 3'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_writeback_arbiter
`default_nettype wire
